// File: rtl/systolic_feeder_pkg.sv
// Shared types and helpers for the systolic array feeder.
package systolic_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    // Zero vectors needed after the last operand so every product reaches the far corner.
    function automatic int feeder_flush_len(input int tile_dim);
        return 2 * tile_dim - 2;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One skew lane: a DEPTH-stage shift register that advances only when enabled.
module skew_lane #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews row/column operand vectors into the systolic array, then flushes zeros.
// Optional SYSTOLIC_FEEDER_PERF_EN adds a stall_cnt output.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int TILE_DIM   = 64,
    parameter int DATA_WIDTH = 16,
    parameter int K_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [K_WIDTH-1:0]               k_len,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [0:TILE_DIM*DATA_WIDTH-1]   s_row,
    input  logic [0:TILE_DIM*DATA_WIDTH-1]   s_col,
    output logic [0:TILE_DIM*DATA_WIDTH-1]   in_row,
    output logic [0:TILE_DIM*DATA_WIDTH-1]   in_col,
    output logic                             enb,
    output logic                             busy,
    output logic                             done
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [31:0]                      stall_cnt
`endif
);

    localparam int FLUSH_LEN = feeder_flush_len(TILE_DIM);
    localparam int FW        = $clog2(FLUSH_LEN + 2);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN);

    feeder_state_e      state, state_nx;
    logic [K_WIDTH-1:0] k_len_q, kcnt;
    logic [FW-1:0]      fcnt;
    logic               adv, clr, streaming;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FLUSH holds one extra non-advancing cycle so the final enb pulse precedes done.
    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        adv      = 1'b0;
        clr      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_nx = STREAM;
                        clr      = 1'b1;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            STREAM: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    adv = 1'b1;
                    if (kcnt == k_len_q - 1'b1) state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (fcnt == FLUSH_LAST) state_nx = DONE;
                else                    adv      = 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_q <= '0;
            kcnt    <= '0;
            fcnt    <= '0;
            enb     <= 1'b0;
        end else begin
            enb <= adv;
            if (state == IDLE && start) begin
                k_len_q <= k_len;
                kcnt    <= '0;
            end else if (state == STREAM && s_valid) begin
                kcnt <= kcnt + 1'b1;
            end
            fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign streaming = (state == STREAM);

`ifdef SYSTOLIC_FEEDER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == STREAM && !s_valid && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

    // Lane i gets i+1 stages; FLUSH feeds zeros into stage 0.
    for (genvar i = 0; i < TILE_DIM; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] row_d, col_d;
        assign row_d = streaming ? s_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign col_d = streaming ? s_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_lane #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_row (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (adv),
            .d   (row_d),
            .q   (in_row[i*DATA_WIDTH +: DATA_WIDTH])
        );

        skew_lane #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_col (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (adv),
            .d   (col_d),
            .q   (in_col[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
